dm_ctrl: RTL and testbench

DM_CTRL -- requirements
Module: dm_ctrl

---
 rtl/dm_ctrl.sv | 155 +++++++++++++++
 tb/tb_dm_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dm_ctrl.sv
// Data-memory controller: one load/store in flight, optional wait states,
// byte/half/word lanes with sign/zero extension and misalignment flagging.
module dm_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [1:0]  size_q;
  logic        sext_q;

  logic [31:0] mem [0:DEPTH-1];

  logic [ADDR_W-1:0] idx;
  logic [31:0]       cur;
  logic              misalign;
  logic [3:0]        be;
  logic [31:0]       lane_data;
  logic [31:0]       merged;
  logic [31:0]       load_val;
  logic [7:0]        byte_f;
  logic [15:0]       half_f;
  logic              unused_bits;

  // Address bits above the implemented depth are deliberately ignored.
  assign unused_bits = ^addr_q[31:ADDR_W+2];
  assign dbg_state   = state;

  always_comb begin
    idx       = addr_q[ADDR_W+1:2];
    cur       = mem[idx];
    misalign  = (size_q == 2'b11) ||
                (size_q == 2'b01 && addr_q[0]) ||
                (size_q == 2'b10 && addr_q[1:0] != 2'b00);
    byte_f    = 8'(cur >> {addr_q[1:0], 3'b000});
    half_f    = 16'(cur >> {addr_q[1], 4'b0000});
    be        = 4'b0000;
    lane_data = wd_q;
    load_val  = cur;
    case (size_q)
      2'b00: begin
        be        = 4'b0001 << addr_q[1:0];
        lane_data = {4{wd_q[7:0]}};
        load_val  = sext_q ? {{24{byte_f[7]}}, byte_f} : {24'd0, byte_f};
      end
      2'b01: begin
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wd_q[15:0]}};
        load_val  = sext_q ? {{16{half_f[15]}}, half_f} : {16'd0, half_f};
      end
      2'b10: begin
        be = 4'b1111;
      end
      default: begin
        be = 4'b0000;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? lane_data[8*i +: 8] : cur[8*i +: 8];
    end
  end

  // Memory has no reset; a write happens only on the ACCESS closing edge.
  always_ff @(posedge clk) begin
    if (!rst && state == S_ACCESS && we_q && !misalign) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      rdata    <= 32'd0;
      addr_err <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wd_q     <= 32'd0;
      size_q   <= 2'b00;
      sext_q   <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q   <= we;
            addr_q <= addr;
            wd_q   <= wd;
            size_q <= size;
            sext_q <= sext;
            busy   <= 1'b1;
            if (WAIT_CYC > 0) begin
              state <= S_WAIT;
              cnt   <= WAIT_LOAD;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          state    <= S_RESP;
          ready    <= 1'b1;
          addr_err <= misalign;
          rdata    <= (we_q || misalign) ? 32'd0 : load_val;
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl: one instance with no wait states, one with three.
// Expected {addr_err, rdata} pairs queue up at request time and pop on ready.
module tb_dm_ctrl;

  logic        clk;
  logic [1:0]  rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic [1:0]  size [2];
  logic [1:0]  sext;
  logic [1:0]  busy;
  logic [1:0]  ready;
  logic [31:0] rdata [2];
  logic [1:0]  addr_err;
  logic [1:0]  dbg_state [2];

  logic [32:0] exp_q[$];
  int          tests;
  int          fails;
  logic [31:0] mm [6];

  dm_ctrl #(.ADDR_W(10), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wd(wd[0]), .size(size[0]), .sext(sext[0]), .busy(busy[0]),
    .ready(ready[0]), .rdata(rdata[0]), .addr_err(addr_err[0]),
    .dbg_state(dbg_state[0])
  );

  dm_ctrl #(.ADDR_W(10), .WAIT_CYC(3)) dut3 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wd(wd[1]), .size(size[1]), .sext(sext[1]), .busy(busy[1]),
    .ready(ready[1]), .rdata(rdata[1]), .addr_err(addr_err[1]),
    .dbg_state(dbg_state[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request on instance d and wait (bounded) for its ready pulse.
  // With spam set, req toggles randomly while busy to prove it is ignored.
  task automatic access(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] data, input logic [1:0] sz,
                        input logic sx, input logic [31:0] exp_rd,
                        input logic exp_err, input logic spam, input string tag);
    int          n;
    bit          done;
    logic [32:0] exp;
    exp_q.push_back({exp_err, exp_rd});
    @(negedge clk);
    we[d] = w; addr[d] = a; wd[d] = data; size[d] = sz; sext[d] = sx;
    req[d] = 1'b1;
    n = 0;
    done = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) check({tag, "_busy"}, 64'(busy[d]), 64'd1);
      if (ready[d]) done = 1;
      else req[d] = spam ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    req[d] = 1'b0;
    exp = exp_q.pop_front();
    if (!done) begin
      check({tag, "_ready"}, 64'(ready[d]), 64'd1);
    end else begin
      check({tag, "_data"}, 64'({addr_err[d], rdata[d]}), 64'(exp));
      check({tag, "_lat"}, 64'(n), (d == 0) ? 64'd2 : 64'd5);
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle"}, 64'({busy[d], ready[d]}), 64'd0);
    if (spam) begin
      repeat (2) begin
        @(posedge clk);
        @(negedge clk);
        check({tag, "_noextra"}, 64'(ready[d]), 64'd0);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 2'b11; req = 2'b00; we = 2'b00; sext = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i] = 32'd0; wd[i] = 32'd0; size[i] = 2'b00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 2'b00;
    for (int i = 0; i < 2; i++) begin
      check("rst_outs", 64'({busy[i], ready[i], addr_err[i], rdata[i]}), 64'd0);
      check("rst_state", 64'(dbg_state[i]), 64'd0);
    end

    // No-wait instance: lane writes and extension
    access(0, 1, 32'h10, 32'h12345678, 2'b10, 0, 32'h0, 0, 0, "st_w10");
    access(0, 0, 32'h10, 32'h0, 2'b10, 0, 32'h12345678, 0, 0, "ld_w10");
    access(0, 1, 32'h11, 32'h000000AB, 2'b00, 0, 32'h0, 0, 0, "st_b11");
    access(0, 0, 32'h11, 32'h0, 2'b00, 1, 32'hFFFFFFAB, 0, 0, "ld_b11_s");
    access(0, 0, 32'h11, 32'h0, 2'b00, 0, 32'h000000AB, 0, 0, "ld_b11_z");
    access(0, 0, 32'h10, 32'h0, 2'b10, 0, 32'h1234AB78, 0, 0, "ld_w10_b");
    access(0, 1, 32'h12, 32'h00008001, 2'b01, 0, 32'h0, 0, 0, "st_h12");
    access(0, 0, 32'h12, 32'h0, 2'b01, 1, 32'hFFFF8001, 0, 0, "ld_h12_s");
    access(0, 0, 32'h13, 32'h0, 2'b01, 1, 32'h0, 1, 0, "ld_h13_err");
    access(0, 1, 32'h13, 32'h00005555, 2'b01, 0, 32'h0, 1, 0, "st_h13_err");
    access(0, 0, 32'h10, 32'h0, 2'b10, 0, 32'h8001AB78, 0, 0, "ld_w10_h");
    access(0, 0, 32'h10, 32'h0, 2'b01, 0, 32'h0000AB78, 0, 0, "ld_h10_z");
    access(0, 0, 32'h13, 32'h0, 2'b00, 1, 32'hFFFFFF80, 0, 0, "ld_b13_s");
    access(0, 0, 32'h12, 32'h0, 2'b00, 0, 32'h00000001, 0, 0, "ld_b12_z");
    access(0, 0, 32'hF0000010, 32'h0, 2'b10, 0, 32'h8001AB78, 0, 0, "ld_hi_ign");

    // Illegal size and misaligned word
    access(0, 1, 32'h24, 32'hCAFEF00D, 2'b10, 0, 32'h0, 0, 0, "st_w24");
    access(0, 1, 32'h24, 32'h11111111, 2'b11, 0, 32'h0, 1, 0, "st_sz11");
    access(0, 0, 32'h24, 32'h0, 2'b11, 0, 32'h0, 1, 0, "ld_sz11");
    access(0, 0, 32'h26, 32'h0, 2'b10, 0, 32'h0, 1, 0, "ld_w26_err");
    access(0, 0, 32'h24, 32'h0, 2'b10, 0, 32'hCAFEF00D, 0, 0, "ld_w24");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold_rdata", 64'({addr_err[0], rdata[0]}), 64'({1'b0, 32'hCAFEF00D}));

    // Random words, then random byte lanes read back
    for (int i = 0; i < 6; i++) begin
      mm[i] = $urandom;
      access(0, 1, 32'h100 + 32'(4 * i), mm[i], 2'b10, 0, 32'h0, 0, 0, "rnd_st");
    end
    for (int i = 0; i < 6; i++) begin
      int          lane;
      logic [31:0] e;
      lane = $urandom_range(0, 3);
      e = (mm[i] >> (8 * lane)) & 32'hFF;
      access(0, 0, 32'h100 + 32'(4 * i + lane), 32'h0, 2'b00, 0, e, 0, 0, "rnd_ld");
    end

    // Three-wait instance: latency, ignored req during busy
    access(1, 1, 32'h20, 32'h0BADF00D, 2'b10, 0, 32'h0, 0, 1, "w3_st20");
    access(1, 0, 32'h20, 32'h0, 2'b10, 0, 32'h0BADF00D, 0, 1, "w3_ld20");
    access(1, 0, 32'h21, 32'h0, 2'b00, 1, 32'hFFFFFFF0, 0, 1, "w3_ldb21");

    // Reset during WAIT aborts the store
    @(negedge clk);
    we[1] = 1'b1; addr[1] = 32'h20; wd[1] = 32'hDEADBEEF; size[1] = 2'b10;
    req[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    check("abort_busy", 64'(busy[1]), 64'd1);
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    check("abort_outs", 64'({busy[1], ready[1], addr_err[1], rdata[1]}), 64'd0);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      check("abort_noready", 64'(ready[1]), 64'd0);
    end
    access(1, 0, 32'h20, 32'h0, 2'b10, 0, 32'h0BADF00D, 0, 0, "abort_ld20");

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
